// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps one memory request in flight, and buffers
// returned words in a small FIFO for decode. Optional macro FETCH_BYPASS_EN adds a mem->decode bypass.
module fetch_unit #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 16,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               hlt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [3:0] HLT_OP = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0]  req_addr;
  logic               stop_fetch;
  logic [INSTR_W-1:0] fifo_instr [DEPTH];
  logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;

  logic ack_take;
  logic bypass;
  logic push;
  logic pop_fifo;
  logic accept;
  logic fifo_nonempty;

  assign fifo_nonempty = (count != '0);
  assign ack_take      = (state == WAIT) && mem_ack && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass      = ack_take && !fifo_nonempty;
  assign instr_valid = fifo_nonempty || bypass;
  assign instr       = bypass ? mem_rdata : fifo_instr[rd_ptr];
  assign instr_pc    = bypass ? req_addr  : fifo_pc[rd_ptr];
`else
  assign bypass      = 1'b0;
  assign instr_valid = fifo_nonempty;
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
`endif

  // A bypassed word that decode takes immediately never enters the FIFO.
  assign push     = ack_take && !(bypass && instr_ready);
  assign pop_fifo = fifo_nonempty && instr_ready;
  assign accept   = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DISCARD is left only by an ack, even under a fresh redirect, so a stale
  // response can never be mistaken for the answer to a newer request.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mem_req) state_next = WAIT;
      end
      WAIT: begin
        if (redirect_valid) state_next = mem_ack ? IDLE : DISCARD;
        else if (mem_ack)   state_next = IDLE;
      end
      DISCARD: begin
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_addr = pc;
    if (rst_n && (state == IDLE) && !stop_fetch && !redirect_valid && (count < DEPTH_CNT)) begin
      mem_req = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= ADDR_W'(RESET_PC);
      req_addr   <= ADDR_W'(RESET_PC);
      stop_fetch <= 1'b0;
      hlt        <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (accept && (instr[INSTR_W-1 -: 4] == HLT_OP)) hlt <= 1'b1;
      if (redirect_valid) begin
        pc         <= redirect_pc;
        stop_fetch <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
      end else begin
        if (mem_req) begin
          pc       <= pc + ADDR_W'(PC_STEP);
          req_addr <= pc;
        end
        if (ack_take && (mem_rdata[INSTR_W-1 -: 4] == HLT_OP)) stop_fetch <= 1'b1;
        if (push)     wr_ptr <= wr_ptr + 1'b1;
        if (pop_fifo) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop_fifo})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr]    <= req_addr;
    end
  end

endmodule
